store_drain_sched: RTL and testbench

Sequences committed stores from the store queue into the single D-cache write port. Commit raises up to two store-fire pulses per cycle. This block counts committed-but-unwritten stores, issues the store-queue head to the D-cache under a req/ack handshake, and pops the head on acceptance. It backpressures Commit when it cannot absorb two more fires, and reports drain status for SYNC/ERET/exception sequencing.

---
 rtl/store_drain_sched.sv | 109 ++++++++++
 tb/tb_store_drain_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/store_drain_sched.sv
// Drains committed stores from the store-queue head into the single D-cache write port.
// Tracks committed-but-unwritten stores, issues the head under req/ack, and backpressures Commit.
module store_drain_sched #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fire0,
    input  logic        fire1,
    output logic        commit_stall,
    input  logic [31:0] sq_head_addr,
    input  logic [31:0] sq_head_data,
    input  logic [3:0]  sq_head_be,
    input  logic        sq_head_uc,
    output logic        sq_pop,
    output logic        dc_req,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    output logic [3:0]  dc_be,
    output logic        dc_uc,
    input  logic        dc_ack,
    output logic        drained,
    output logic        uc_busy,
    output logic        err
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic signed [CW+1:0] cnt_sum;
    logic                 capture;
    logic                 fire_any;
    logic                 violation;

    // Clamp the net count into [0, DEPTH]; only a protocol violation can push it outside.
    function automatic logic [CW-1:0] sat_cnt(input logic signed [CW+1:0] v);
        logic [CW-1:0] r;
        if (v < 0)
            r = '0;
        else if (v > $signed((CW+2)'(DEPTH)))
            r = CW'(DEPTH);
        else
            r = v[CW-1:0];
        return r;
    endfunction

    assign dc_req       = (state == ISSUE);
    assign sq_pop       = dc_req & dc_ack;
    assign uc_busy      = dc_req & dc_uc;
    assign drained      = (cnt == '0) && (state == IDLE);
    assign commit_stall = (CW'(DEPTH) - cnt) < CW'(2);
    assign fire_any     = fire0 | fire1;

    assign violation = (fire1 & ~fire0)
                     | (fire_any & commit_stall)
                     | (sq_pop & (cnt == '0));

    always_comb begin
        cnt_sum  = $signed({2'b00, cnt})
                 + $signed({{(CW+1){1'b0}}, fire0})
                 + $signed({{(CW+1){1'b0}}, fire1})
                 - $signed({{(CW+1){1'b0}}, sq_pop});
        cnt_next = sat_cnt(cnt_sum);
    end

    // The unconditional return to IDLE after a pop gives the store-queue head a cycle to advance.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (cnt != '0) begin
                    state_next = ISSUE;
                    capture    = 1'b1;
                end
            end
            ISSUE: begin
                if (dc_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            err      <= 1'b0;
            dc_addr  <= '0;
            dc_wdata <= '0;
            dc_be    <= '0;
            dc_uc    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err   <= err | violation;
            if (capture) begin
                dc_addr  <= sq_head_addr;
                dc_wdata <= sq_head_data;
                dc_be    <= sq_head_be;
                dc_uc    <= sq_head_uc;
            end
        end
    end

endmodule

// File: tb/tb_store_drain_sched.sv
// Directed bench for store_drain_sched: reset, issue latency, slow ack, backpressure,
// same-cycle fire/ack and protocol violations with an asynchronous mid-request reset.
module tb_store_drain_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        fire0, fire1;
    logic        commit_stall;
    logic [31:0] sq_head_addr, sq_head_data;
    logic [3:0]  sq_head_be;
    logic        sq_head_uc;
    logic        sq_pop;
    logic        dc_req;
    logic [31:0] dc_addr, dc_wdata;
    logic [3:0]  dc_be;
    logic        dc_uc;
    logic        dc_ack;
    logic        drained, uc_busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    store_drain_sched #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .fire0(fire0), .fire1(fire1), .commit_stall(commit_stall),
        .sq_head_addr(sq_head_addr), .sq_head_data(sq_head_data), .sq_head_be(sq_head_be),
        .sq_head_uc(sq_head_uc), .sq_pop(sq_pop), .dc_req(dc_req), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_be(dc_be), .dc_uc(dc_uc), .dc_ack(dc_ack),
        .drained(drained), .uc_busy(uc_busy), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; fire0 = 0; fire1 = 0; dc_ack = 0;
        sq_head_addr = '0; sq_head_data = '0; sq_head_be = '0; sq_head_uc = 0;
        #2;
        n_cmp++; if (dc_req !== 1'b0) begin n_bad++; $display("FAIL rst_dc_req: got %b want 0", dc_req); end
        repeat (3) cyc();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL idle_drained[%0d]: got %b want 1", i, drained); end
            n_cmp++; if (dc_req !== 1'b0) begin n_bad++; $display("FAIL idle_dc_req[%0d]: got %b want 0", i, dc_req); end
        end
        n_cmp++; if (commit_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", commit_stall); end
        n_cmp++; if (sq_pop !== 1'b0) begin n_bad++; $display("FAIL rst_pop: got %b want 0", sq_pop); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (uc_busy !== 1'b0) begin n_bad++; $display("FAIL rst_uc_busy: got %b want 0", uc_busy); end
        n_cmp++; if ({dc_addr, dc_wdata, dc_be, dc_uc} !== 69'd0) begin n_bad++; $display("FAIL rst_payload: got %h/%h/%h/%b want 0", dc_addr, dc_wdata, dc_be, dc_uc); end
    endtask

    task automatic test_single();
        dc_ack = 1'b1;
        sq_head_addr = 32'h8000_0010; sq_head_data = 32'hDEAD_BEEF; sq_head_be = 4'hF; sq_head_uc = 0;
        cyc(); fire0 = 1'b1;
        cyc(); fire0 = 1'b0; #1;
        n_cmp++; if (dc_req !== 1'b0) begin n_bad++; $display("FAIL single_req_t1: got %b want 0", dc_req); end
        n_cmp++; if (drained !== 1'b0) begin n_bad++; $display("FAIL single_drained_t1: got %b want 0", drained); end
        cyc(); #1;
        n_cmp++; if (dc_req !== 1'b1) begin n_bad++; $display("FAIL single_req_t2: got %b want 1", dc_req); end
        n_cmp++; if (dc_addr !== 32'h8000_0010) begin n_bad++; $display("FAIL single_addr: got %h want 80000010", dc_addr); end
        n_cmp++; if (dc_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_wdata: got %h want deadbeef", dc_wdata); end
        n_cmp++; if (dc_be !== 4'hF) begin n_bad++; $display("FAIL single_be: got %h want f", dc_be); end
        n_cmp++; if (sq_pop !== 1'b1) begin n_bad++; $display("FAIL single_pop: got %b want 1", sq_pop); end
        cyc(); #1;
        n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL single_drained_t3: got %b want 1", drained); end
        n_cmp++; if (dc_req !== 1'b0) begin n_bad++; $display("FAIL single_req_t3: got %b want 0", dc_req); end
        dc_ack = 1'b0;
    endtask

    task automatic test_dual_slow();
        int pops;
        pops = 0;
        sq_head_addr = 32'h1000_0004; sq_head_data = 32'h1122_3344; sq_head_be = 4'h3; sq_head_uc = 0;
        cyc(); fire0 = 1; fire1 = 1;
        cyc(); fire0 = 0; fire1 = 0; #1;
        n_cmp++; if (dut.cnt !== 4'd2) begin n_bad++; $display("FAIL dual_cnt: got %0d want 2", dut.cnt); end
        for (int w = 0; w < 3; w++) begin
            cyc();
            sq_head_addr = 32'hBAD0_0000 + w; sq_head_data = 32'h5555_0000 + w; sq_head_be = 4'hC;
            #1;
            n_cmp++; if (dc_req !== 1'b1) begin n_bad++; $display("FAIL dual_wait_req[%0d]: got %b want 1", w, dc_req); end
            n_cmp++; if (dc_addr !== 32'h1000_0004 || dc_wdata !== 32'h1122_3344 || dc_be !== 4'h3)
                begin n_bad++; $display("FAIL dual_hold[%0d]: got %h/%h/%h want 10000004/11223344/3", w, dc_addr, dc_wdata, dc_be); end
            n_cmp++; if (sq_pop !== 1'b0) begin n_bad++; $display("FAIL dual_wait_pop[%0d]: got %b want 0", w, sq_pop); end
        end
        cyc(); dc_ack = 1; #1;
        if (sq_pop === 1'b1) pops++;
        cyc(); dc_ack = 0;
        sq_head_addr = 32'h2000_0008; sq_head_data = 32'hCAFE_F00D; sq_head_be = 4'h1; #1;
        n_cmp++; if (dc_req !== 1'b0) begin n_bad++; $display("FAIL dual_gap_req: got %b want 0", dc_req); end
        n_cmp++; if (drained !== 1'b0) begin n_bad++; $display("FAIL dual_mid_drained: got %b want 0", drained); end
        cyc(); dc_ack = 1; #1;
        if (sq_pop === 1'b1) pops++;
        n_cmp++; if (dc_addr !== 32'h2000_0008 || dc_wdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL dual_second: got %h/%h want 20000008/cafef00d", dc_addr, dc_wdata); end
        cyc(); dc_ack = 0; #1;
        n_cmp++; if (drained !== 1'b1) begin n_bad++; $display("FAIL dual_drained: got %b want 1", drained); end
        n_cmp++; if (pops !== 2) begin n_bad++; $display("FAIL dual_pops: got %0d want 2", pops); end
    endtask

    task automatic test_backpressure();
        int mc, pops;
        bit done;
        mc = 0; pops = 0; done = 0;
        dc_ack = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(); fire0 = 0; fire1 = 0; #1;
            n_cmp++; if (commit_stall !== (mc >= 7)) begin n_bad++; $display("FAIL bp_stall[%0d]: got %b want %b", i, commit_stall, (mc >= 7)); end
            n_cmp++; if (int'(dut.cnt) !== mc) begin n_bad++; $display("FAIL bp_cnt[%0d]: got %0d want %0d", i, dut.cnt, mc); end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bp_err[%0d]: got %b want 0", i, err); end
            if (mc < 7) begin fire0 = 1; fire1 = 1; mc += 2; end
        end
        for (int i = 0; i < 40 && !done; i++) begin
            cyc(); fire0 = 0; fire1 = 0; dc_ack = 1; #1;
            if (sq_pop === 1'b1) pops++;
            if (drained === 1'b1) done = 1;
        end
        dc_ack = 0;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp_drain_timeout: got drained=%b want 1", drained); end
        n_cmp++; if (pops !== 8) begin n_bad++; $display("FAIL bp_pops: got %0d want 8", pops); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bp_err_end: got %b want 0", err); end
    endtask

    task automatic test_fire_ack();
        int pops;
        bit done;
        pops = 0; done = 0;
        sq_head_addr = 32'h3000_0000; sq_head_data = 32'h0; sq_head_be = 4'hF;
        cyc(); fire0 = 1; fire1 = 1;
        cyc(); fire0 = 1; fire1 = 0;
        cyc(); fire0 = 1; fire1 = 1; dc_ack = 1; #1;
        n_cmp++; if (dut.cnt !== 4'd3) begin n_bad++; $display("FAIL fa_cnt_before: got %0d want 3", dut.cnt); end
        n_cmp++; if (sq_pop !== 1'b1) begin n_bad++; $display("FAIL fa_pop: got %b want 1", sq_pop); end
        cyc(); fire0 = 0; fire1 = 0; #1;
        n_cmp++; if (dut.cnt !== 4'd4) begin n_bad++; $display("FAIL fa_cnt_after: got %0d want 4", dut.cnt); end
        n_cmp++; if (sq_pop !== 1'b0) begin n_bad++; $display("FAIL fa_single_pop: got %b want 0", sq_pop); end
        for (int i = 0; i < 30 && !done; i++) begin
            cyc(); #1;
            if (sq_pop === 1'b1) pops++;
            if (drained === 1'b1) done = 1;
        end
        dc_ack = 0;
        n_cmp++; if (pops !== 4 || done !== 1'b1) begin n_bad++; $display("FAIL fa_drain: got pops=%0d drained=%b want 4/1", pops, done); end
    endtask

    task automatic test_violation();
        sq_head_addr = 32'hBF00_0000; sq_head_data = 32'h0000_00AA; sq_head_be = 4'h1; sq_head_uc = 1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL viol_pre_err: got %b want 0", err); end
        cyc(); fire0 = 0; fire1 = 1;
        cyc(); fire1 = 0; #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL viol_err: got %b want 1", err); end
        cyc(); #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL viol_sticky: got %b want 1", err); end
        n_cmp++; if (uc_busy !== 1'b1 || dc_req !== 1'b1) begin n_bad++; $display("FAIL viol_uc_busy: got uc_busy=%b dc_req=%b want 1/1", uc_busy, dc_req); end
        rst = 1'b0; #1;
        n_cmp++; if (dc_req !== 1'b0) begin n_bad++; $display("FAIL async_req: got %b want 0", dc_req); end
        n_cmp++; if (uc_busy !== 1'b0) begin n_bad++; $display("FAIL async_uc_busy: got %b want 0", uc_busy); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL async_err: got %b want 0", err); end
        cyc(); rst = 1'b1; sq_head_uc = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_slow();
        test_backpressure();
        test_fire_ack();
        test_violation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
